bus_arbiter: RTL and testbench

- Shares one single-port instruction/data memory bus between the IF stage (fetch) and the MEM stage (load/store).
- Sits between the pipeline top and external memory.
- Serialises the two requesters into one registered bus transaction at a time.
- Drives the pipeline stall vector while a requester waits, and discards fetches killed by a pipeline flush.

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arbiter_wdt.sv | 31 +++
 rtl/bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared widths, state encodings and stall vectors for the memory bus arbiter
package bus_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DM   = 2'd1,
        ARB_IF   = 2'd2,
        ARB_DROP = 2'd3
    } arb_state_t;

    // Stall bit order is {wb, mem, ex, id, if, pc}
    localparam logic [5:0] StallNone  = 6'b000000;
    localparam logic [5:0] StallFetch = 6'b000011;
    localparam logic [5:0] StallData  = 6'b011111;

    localparam logic [3:0] SelAll = 4'hF;

endpackage

// File: rtl/bus_arbiter_wdt.sv
// rtl/bus_arbiter_wdt.sv - bus transaction watchdog counter, built only with ARB_TIMEOUT_EN
module arb_wdt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);

    logic [31:0] count;

    // Restart on every new transaction phase, count only cycles spent waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (active && !ack) begin
            count <= count + 32'd1;
        end
    end

    // Fires during the last allowed wait cycle so the FSM gives up on that edge
    always_comb begin
        expired = active && !ack && (count == (TIMEOUT_CYCLES - 32'd1));
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - fetch/data memory bus arbiter with flush drop; ARB_TIMEOUT_EN adds a watchdog
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int          ADDR_W         = ARB_ADDR_W,
    parameter int          DATA_W         = ARB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_sel_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    input  logic              flush_i,
    output logic              bus_cyc_o,
    output logic              bus_stb_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic [5:0]        stall_o,
    output logic              err_o
);

    arb_state_t state;
    logic       dm_go;
    logic       if_go;
    logic       wdt_expired;

    // A requester is eligible only once its previous ack pulse has gone
    assign dm_go = dm_req_i && !dm_ack_o;
    assign if_go = if_req_i && !if_ack_o && !flush_i;

`ifdef ARB_TIMEOUT_EN
    logic wdt_start;

    assign wdt_start = ((state == ARB_IDLE) && (dm_go || if_go)) ||
                       ((state == ARB_IF) && flush_i && !bus_ack_i);

    arb_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .start  (wdt_start),
        .active (state != ARB_IDLE),
        .ack    (bus_ack_i),
        .expired(wdt_expired)
    );
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wdt_expired    = 1'b0;
`endif

    // Pipeline stall: a waiting load/store freezes up to mem, a waiting fetch freezes pc/if
    always_comb begin
        stall_o = StallNone;
        if (dm_go) begin
            stall_o = StallData;
        end else if (if_go) begin
            stall_o = StallFetch;
        end
    end

    // Arbiter FSM: data wins over fetch, one registered bus transaction at a time
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            bus_cyc_o   <= 1'b0;
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'h0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_rdata_o  <= '0;
            if_ack_o    <= 1'b0;
            dm_rdata_o  <= '0;
            dm_ack_o    <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;
            err_o    <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (dm_go) begin
                        state       <= ARB_DM;
                        bus_cyc_o   <= 1'b1;
                        bus_stb_o   <= 1'b1;
                        bus_we_o    <= dm_we_i;
                        bus_sel_o   <= dm_sel_i;
                        bus_addr_o  <= dm_addr_i;
                        bus_wdata_o <= dm_wdata_i;
                    end else if (if_go) begin
                        state       <= ARB_IF;
                        bus_cyc_o   <= 1'b1;
                        bus_stb_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= SelAll;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                    end
                end
                ARB_DM: begin
                    if (bus_ack_i) begin
                        state      <= ARB_IDLE;
                        bus_cyc_o  <= 1'b0;
                        bus_stb_o  <= 1'b0;
                        dm_rdata_o <= bus_rdata_i;
                        dm_ack_o   <= 1'b1;
                    end else if (wdt_expired) begin
                        state      <= ARB_IDLE;
                        bus_cyc_o  <= 1'b0;
                        bus_stb_o  <= 1'b0;
                        dm_rdata_o <= '0;
                        dm_ack_o   <= 1'b1;
                        err_o      <= 1'b1;
                    end
                end
                ARB_IF: begin
                    if (bus_ack_i) begin
                        state     <= ARB_IDLE;
                        bus_cyc_o <= 1'b0;
                        bus_stb_o <= 1'b0;
                        if (!flush_i) begin
                            if_rdata_o <= bus_rdata_i;
                            if_ack_o   <= 1'b1;
                        end
                    end else if (wdt_expired) begin
                        state      <= ARB_IDLE;
                        bus_cyc_o  <= 1'b0;
                        bus_stb_o  <= 1'b0;
                        if_rdata_o <= '0;
                        if_ack_o   <= 1'b1;
                        err_o      <= 1'b1;
                    end else if (flush_i) begin
                        // The slave still owes an ack, so let the cycle finish unseen
                        state <= ARB_DROP;
                    end
                end
                ARB_DROP: begin
                    if (bus_ack_i || wdt_expired) begin
                        state     <= ARB_IDLE;
                        bus_cyc_o <= 1'b0;
                        bus_stb_o <= 1'b0;
                        err_o     <= !bus_ack_i;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    bus_cyc_o <= 1'b0;
                    bus_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter: vector table, directed corners, random model
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        flush_i;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic [5:0]  stall_o;
    logic        err_o;

    int tests  = 0;
    int failed = 0;

    bus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_ack_o   (if_ack_o),
        .dm_req_i   (dm_req_i),
        .dm_we_i    (dm_we_i),
        .dm_sel_i   (dm_sel_i),
        .dm_addr_i  (dm_addr_i),
        .dm_wdata_i (dm_wdata_i),
        .dm_rdata_o (dm_rdata_o),
        .dm_ack_o   (dm_ack_o),
        .flush_i    (flush_i),
        .bus_cyc_o  (bus_cyc_o),
        .bus_stb_o  (bus_stb_o),
        .bus_we_o   (bus_we_o),
        .bus_sel_o  (bus_sel_o),
        .bus_addr_o (bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i),
        .bus_ack_i  (bus_ack_i),
        .stall_o    (stall_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dm_req;
        logic       if_req;
        logic       flush;
        logic [5:0] stall;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        dm_req_i    = 1'b0;
        dm_we_i     = 1'b0;
        dm_sel_i    = 4'h0;
        dm_addr_i   = '0;
        dm_wdata_i  = '0;
        flush_i     = 1'b0;
        bus_rdata_i = '0;
        bus_ack_i   = 1'b0;
    endtask

    // random-phase model state
    logic        exp_dm_v, exp_if_v, flushed, p_cyc, p_ack;
    logic [31:0] exp_dm_d, exp_if_d;
    logic        p_dm_req, p_dm_ack, p_dm_we, p_if_req, p_if_ack, p_flush;
    logic [3:0]  p_dm_sel;
    logic [31:0] p_dm_addr, p_dm_wdata, p_if_addr;
    logic [68:0] l_fields;
    logic        el_dm, el_if;
    logic [5:0]  exp_stall;
    int          wait_cnt, dm_wait, if_wait;

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();

        // stall vector is combinational from requests; held in reset so no ack is visible
        vecs[0] = '{1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 6'b000000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 6'b000011};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 6'b000000};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 6'b011111};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 6'b011111};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 6'b011111};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 6'b011111};
        for (int i = 0; i < 8; i++) begin
            dm_req_i = vecs[i].dm_req;
            if_req_i = vecs[i].if_req;
            flush_i  = vecs[i].flush;
            #1;
            chk($sformatf("stall_vec%0d", i), stall_o, vecs[i].stall);
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_cyc", bus_cyc_o, 0);
        chk("rst_stb", bus_stb_o, 0);
        chk("rst_fields", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 0);
        chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 0);
        chk("rst_acks", {if_ack_o, dm_ack_o, err_o}, 0);
        chk("rst_stall", stall_o, 0);

        // zero-wait fetch
        if_req_i = 1'b1; if_addr_i = 32'h100;
        #1 chk("t1_stall_c0", stall_o, 6'b000011);
        tick();
        chk("t1_cyc", {bus_cyc_o, bus_stb_o}, 2'b11);
        chk("t1_fields", {bus_addr_o, bus_sel_o, bus_we_o}, {32'h100, 4'hF, 1'b0});
        chk("t1_stall_c1", stall_o, 6'b000011);
        chk("t1_noack_c1", if_ack_o, 0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3C01_0010;
        tick();
        chk("t1_ack", if_ack_o, 1);
        chk("t1_rdata", if_rdata_o, 32'h3C01_0010);
        chk("t1_cyc_off", bus_cyc_o, 0);
        chk("t1_stall_c2", stall_o, 0);
        idle_inputs();
        tick();
        chk("t1_ack_pulse", {if_ack_o, bus_cyc_o}, 0);

        // simultaneous store and fetch
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEAD_BEEF; dm_sel_i = 4'h3;
        if_req_i = 1'b1; if_addr_i = 32'h104;
        #1 chk("t2_stall", stall_o, 6'b011111);
        tick();
        chk("t2_dm_bus", {bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o},
            {1'b1, 1'b1, 4'h3, 32'h200, 32'hDEAD_BEEF});
        chk("t2_stall_dm", stall_o, 6'b011111);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
        tick();
        chk("t2_dm_ack", dm_ack_o, 1);
        chk("t2_dm_rdata", dm_rdata_o, 32'h0BAD_F00D);
        chk("t2_cyc_gap", bus_cyc_o, 0);
        dm_req_i = 1'b0; bus_ack_i = 1'b0;
        #1 chk("t2_stall_if", stall_o, 6'b000011);
        tick();
        chk("t2_if_bus", {bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o}, {1'b1, 1'b0, 4'hF, 32'h104});
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        tick();
        chk("t2_if_ack", {if_ack_o, if_rdata_o}, {1'b1, 32'h1111_2222});
        idle_inputs();
        tick();

        // load with three wait states
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300; dm_sel_i = 4'hF;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_hold%0d", i), {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o},
                {1'b1, 1'b1, 1'b0, 4'hF, 32'h300});
            chk($sformatf("t3_noack%0d", i), dm_ack_o, 0);
            if (i == 3) begin
                bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
            end else begin
                bus_rdata_i = 32'hFFFF_0000 + 32'(i);
            end
            tick();
        end
        chk("t3_ack", {dm_ack_o, dm_rdata_o, bus_cyc_o}, {1'b1, 32'h1234_5678, 1'b0});
        idle_inputs();
        tick();
        chk("t3_single_pulse", dm_ack_o, 0);

        // flush while fetch is on the bus
        if_req_i = 1'b1; if_addr_i = 32'h180;
        tick();
        chk("t4_launch", {bus_cyc_o, bus_addr_o}, {1'b1, 32'h180});
        flush_i = 1'b1;
        #1 chk("t4_stall_flush", stall_o, 0);
        tick();
        chk("t4_drop_c2", {bus_cyc_o, if_ack_o}, 2'b10);
        flush_i = 1'b0; if_req_i = 1'b0;
        tick();
        chk("t4_drop_c3", {bus_cyc_o, if_ack_o, bus_addr_o}, {2'b10, 32'h180});
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        tick();
        chk("t4_no_ack", {bus_cyc_o, if_ack_o}, 0);
        bus_ack_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h1C0;
        tick();
        chk("t4_next_launch", {bus_cyc_o, bus_addr_o}, {1'b1, 32'h1C0});
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0011;
        tick();
        chk("t4_next_ack", {if_ack_o, if_rdata_o}, {1'b1, 32'h11});
        idle_inputs();
        tick();

        // reset in the middle of a data access
        dm_req_i = 1'b1; dm_addr_i = 32'h400; dm_sel_i = 4'hF;
        tick();
        chk("t5_launch", bus_cyc_o, 1);
        rst = 1'b1;
        tick();
        chk("t5_bus_zero", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 0);
        chk("t5_out_zero", {if_rdata_o, dm_rdata_o, if_ack_o, dm_ack_o, err_o}, 0);
        rst = 1'b0; dm_req_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_CAFE;
        tick();
        chk("t5_late_ack", {dm_ack_o, bus_cyc_o, dm_rdata_o}, 0);
        bus_ack_i = 1'b0;
        tick();
        chk("t5_late_ack2", dm_ack_o, 0);

        // fetch with no ack: watchdog or indefinite wait
        if_req_i = 1'b1; if_addr_i = 32'h1F0;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_wait%0d", i), {bus_cyc_o, err_o, if_ack_o}, 3'b100);
            tick();
        end
        chk("t6_timeout", {err_o, if_ack_o, if_rdata_o, bus_cyc_o}, {2'b11, 32'h0, 1'b0});
        if_req_i = 1'b0;
        tick();
        chk("t6_err_pulse", err_o, 0);
`else
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t6_pending%0d", i), {bus_cyc_o, err_o, if_ack_o, stall_o}, {3'b100, 6'b000011});
            tick();
        end
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_ABCD;
        tick();
        chk("t6_late_ack", {if_ack_o, if_rdata_o, err_o}, {1'b1, 32'hABCD, 1'b0});
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
`endif
        idle_inputs();
        tick();

        // randomized traffic against a transaction-level model
        exp_dm_v = 0; exp_if_v = 0; exp_dm_d = 0; exp_if_d = 0; flushed = 0;
        p_cyc = bus_cyc_o; p_ack = 0; p_dm_req = 0; p_dm_ack = 0; p_if_req = 0; p_if_ack = 0; p_flush = 0;
        p_dm_we = 0; p_dm_sel = 0; p_dm_addr = 0; p_dm_wdata = 0; p_if_addr = 0; l_fields = 0;
        wait_cnt = 0; dm_wait = 0; if_wait = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            chk("r_dm_ack", dm_ack_o, exp_dm_v);
            if (exp_dm_v) chk("r_dm_rdata", dm_rdata_o, exp_dm_d);
            chk("r_if_ack", if_ack_o, exp_if_v);
            if (exp_if_v) chk("r_if_rdata", if_rdata_o, exp_if_d);
            chk("r_err", err_o, 0);
            chk("r_stb", bus_stb_o, bus_cyc_o);
            if (!p_cyc) begin
                el_dm = p_dm_req && !p_dm_ack;
                el_if = p_if_req && !p_if_ack && !p_flush;
                chk("r_launch", bus_cyc_o, el_dm || el_if);
                if (bus_cyc_o) begin
                    if (el_dm)
                        chk("r_dm_fields", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o},
                            {p_dm_we, p_dm_sel, p_dm_addr, p_dm_wdata});
                    else
                        chk("r_if_fields", {bus_we_o, bus_sel_o, bus_addr_o}, {1'b0, 4'hF, p_if_addr});
                    l_fields = {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o};
                    flushed  = 0;
                end
            end else begin
                chk("r_cyc_hold", bus_cyc_o, !p_ack);
                if (bus_cyc_o) chk("r_stable", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, l_fields);
            end

            // data requester: hold until ack, then maybe issue the next one
            if (dm_ack_o) dm_req_i = 1'b0;
            if (!dm_req_i && ($urandom_range(0, 3) == 0)) begin
                dm_req_i   = 1'b1;
                dm_we_i    = 1'($urandom_range(0, 1));
                dm_sel_i   = 4'($urandom_range(1, 15));
                dm_addr_i  = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
                dm_wdata_i = $urandom;
            end
            // fetch requester: a flush redirects the pending fetch to a new address
            if (if_ack_o) if_req_i = 1'b0;
            if (!if_req_i && ($urandom_range(0, 1) == 0)) begin
                if_req_i  = 1'b1;
                if_addr_i = $urandom & 32'h0000_FFFC;
            end
            flush_i = ($urandom_range(0, 7) == 0);
            if (flush_i && if_req_i) if_addr_i = $urandom & 32'h0000_FFFC;

            // memory slave: 0..2 wait states
            bus_rdata_i = $urandom;
            bus_ack_i   = 1'b0;
            if (bus_cyc_o) begin
                if (wait_cnt == 2 || $urandom_range(0, 2) == 0) begin
                    bus_ack_i = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end

            exp_dm_v = bus_cyc_o && bus_ack_i && bus_addr_o[31];
            exp_dm_d = bus_rdata_i;
            if (bus_cyc_o && !bus_addr_o[31] && flush_i) flushed = 1;
            exp_if_v = bus_cyc_o && bus_ack_i && !bus_addr_o[31] && !flushed;
            exp_if_d = bus_rdata_i;

            dm_wait = (dm_req_i && !dm_ack_o) ? dm_wait + 1 : 0;
            if_wait = (if_req_i && !if_ack_o) ? if_wait + 1 : 0;
            if (dm_wait > 40) chk("r_dm_live", dm_wait, 0);
            if (if_wait > 60) chk("r_if_live", if_wait, 0);

            p_cyc = bus_cyc_o; p_ack = bus_ack_i;
            p_dm_req = dm_req_i; p_dm_ack = dm_ack_o; p_dm_we = dm_we_i; p_dm_sel = dm_sel_i;
            p_dm_addr = dm_addr_i; p_dm_wdata = dm_wdata_i;
            p_if_req = if_req_i; p_if_ack = if_ack_o; p_if_addr = if_addr_i; p_flush = flush_i;

            #1;
            if (dm_req_i && !dm_ack_o) exp_stall = 6'b011111;
            else if (if_req_i && !if_ack_o && !flush_i) exp_stall = 6'b000011;
            else exp_stall = 6'b000000;
            chk("r_stall", stall_o, exp_stall);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
